// File: rtl/ov7670_capture.sv
// OV7670 RGB444 capture: turns camera byte pairs into 12-bit pixels and
// writes them linearly into a frame buffer, flagging malformed lines and overruns.
module ov7670_capture #(
    parameter int RESOLUTION_WIDTH  = 640,
    parameter int RESOLUTION_HEIGHT = 480,
    localparam int AW = $clog2(RESOLUTION_WIDTH * RESOLUTION_HEIGHT) + 1
) (
    input  logic          pclk,
    input  logic          rst,
    input  logic          cam_vsync,
    input  logic          cam_href,
    input  logic [7:0]    cam_data,
    output logic [11:0]   w_data,
    output logic [AW-1:0] w_addr,
    output logic          w_en,
    output logic          frame_done,
    output logic          line_err,
    output logic          overflow
);
    localparam int PIXELS     = RESOLUTION_WIDTH * RESOLUTION_HEIGHT;
    localparam int LINE_BYTES = 2 * RESOLUTION_WIDTH;
    localparam int CW         = $clog2(LINE_BYTES + 1) + 1;

    localparam logic [AW-1:0] ADDR_MAX     = AW'(PIXELS);
    localparam logic [CW-1:0] CNT_MAX      = '1;
    localparam logic [CW-1:0] LINE_BYTES_C = CW'(LINE_BYTES);

    typedef enum logic [1:0] {ALIGN, WAIT_START, ACTIVE} state_t;

    state_t        state_q, state_d;
    logic          vsync_q, vsync_prev_q, href_q, href_prev_q;
    logic [7:0]    data_q;
    logic          phase_q, phase_d;
    logic [3:0]    red_q, red_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [11:0]   w_data_q, w_data_d;
    logic [AW-1:0] w_addr_q, w_addr_d;
    logic          w_en_q, w_en_d;
    logic          frame_done_q, frame_done_d;
    logic          line_err_q, line_err_d;
    logic          overflow_q, overflow_d;

    logic vsync_rise, vsync_fall, href_fall, line_bad;

    assign vsync_rise = vsync_q & ~vsync_prev_q;
    assign vsync_fall = ~vsync_q & vsync_prev_q;
    assign href_fall  = ~href_q & href_prev_q;
    assign line_bad   = cnt_q[0] || (cnt_q != LINE_BYTES_C);

    always_ff @(posedge pclk) begin
        if (rst) begin
            state_q      <= ALIGN;
            vsync_q      <= 1'b0;
            vsync_prev_q <= 1'b0;
            href_q       <= 1'b0;
            href_prev_q  <= 1'b0;
            data_q       <= '0;
            phase_q      <= 1'b0;
            red_q        <= '0;
            cnt_q        <= '0;
            w_data_q     <= '0;
            w_addr_q     <= '0;
            w_en_q       <= 1'b0;
            frame_done_q <= 1'b0;
            line_err_q   <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            vsync_q      <= cam_vsync;
            vsync_prev_q <= vsync_q;
            href_q       <= cam_href;
            href_prev_q  <= href_q;
            data_q       <= cam_data;
            phase_q      <= phase_d;
            red_q        <= red_d;
            cnt_q        <= cnt_d;
            w_data_q     <= w_data_d;
            w_addr_q     <= w_addr_d;
            w_en_q       <= w_en_d;
            frame_done_q <= frame_done_d;
            line_err_q   <= line_err_d;
            overflow_q   <= overflow_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ALIGN:      if (vsync_q)    state_d = WAIT_START;
            WAIT_START: if (vsync_fall) state_d = ACTIVE;
            ACTIVE:     if (vsync_rise) state_d = WAIT_START;
            default:                    state_d = ALIGN;
        endcase
    end

    always_comb begin
        phase_d      = phase_q;
        red_d        = red_q;
        cnt_d        = cnt_q;
        w_data_d     = w_data_q;
        w_addr_d     = w_addr_q;
        w_en_d       = 1'b0;
        frame_done_d = 1'b0;
        line_err_d   = line_err_q;
        overflow_d   = overflow_q;

        if (w_en_q && (w_addr_q != ADDR_MAX)) w_addr_d = w_addr_q + AW'(1);

        case (state_q)
            WAIT_START: begin
                if (vsync_fall) begin
                    w_addr_d = '0;
                    phase_d  = 1'b0;
                    cnt_d    = '0;
                end
            end
            ACTIVE: begin
                if (vsync_rise) begin
                    // A line still open when the frame ends is truncated; its bytes are dropped.
                    frame_done_d = 1'b1;
                    phase_d      = 1'b0;
                    cnt_d        = '0;
                    if (href_q || (href_fall && (cnt_q != '0) && line_bad)) line_err_d = 1'b1;
                end else if (href_q) begin
                    phase_d = ~phase_q;
                    cnt_d   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
                    if (!phase_q) begin
                        red_d = data_q[3:0];
                    end else if (w_addr_q >= ADDR_MAX) begin
                        overflow_d = 1'b1;
                    end else begin
                        w_en_d   = 1'b1;
                        w_data_d = {red_q, data_q};
                    end
                end else if (href_fall) begin
                    // A fall with nothing counted belongs to a line seen before the frame began.
                    if ((cnt_q != '0) && line_bad) line_err_d = 1'b1;
                    phase_d = 1'b0;
                    cnt_d   = '0;
                end
            end
            default: ;
        endcase
    end

    assign w_data     = w_data_q;
    assign w_addr     = w_addr_q;
    assign w_en       = w_en_q;
    assign frame_done = frame_done_q;
    assign line_err   = line_err_q;
    assign overflow   = overflow_q;
endmodule

// File: tb/tb_ov7670_capture.sv
// Directed bench for ov7670_capture on a 4x3 frame: timing, addressing,
// line errors, overflow, truncation and reset recovery.
module tb_ov7670_capture;
    localparam int W  = 4;
    localparam int H  = 3;
    localparam int AW = $clog2(W * H) + 1;

    logic          pclk;
    logic          rst;
    logic          cam_vsync;
    logic          cam_href;
    logic [7:0]    cam_data;
    logic [11:0]   w_data;
    logic [AW-1:0] w_addr;
    logic          w_en;
    logic          frame_done;
    logic          line_err;
    logic          overflow;

    int          checks   = 0;
    int          errors   = 0;
    int          wr_count = 0;
    int          fd_count = 0;
    int          exp_addr = 0;
    logic [11:0] exp_data = '0;

    ov7670_capture #(.RESOLUTION_WIDTH(W), .RESOLUTION_HEIGHT(H)) dut (
        .pclk(pclk), .rst(rst), .cam_vsync(cam_vsync), .cam_href(cam_href),
        .cam_data(cam_data), .w_data(w_data), .w_addr(w_addr), .w_en(w_en),
        .frame_done(frame_done), .line_err(line_err), .overflow(overflow)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // Every write seen is checked against the running expected address/data.
    task automatic tick();
        @(posedge pclk);
        #1;
        if (w_en === 1'b1) begin
            check("wr_addr", 32'(w_addr), 32'(exp_addr));
            check("wr_data", 32'(w_data), 32'(exp_data));
            exp_addr++;
            wr_count++;
        end
        if (frame_done === 1'b1) fd_count++;
    endtask

    task automatic send_line(input int n, input logic [7:0] b0, input logic [7:0] b1);
        exp_data = {b0[3:0], b1};
        for (int i = 0; i < n; i++) begin
            cam_href = 1'b1;
            cam_data = (i % 2 == 1) ? b1 : b0;
            tick();
        end
        cam_href = 1'b0;
        cam_data = 8'h00;
        repeat (4) tick();
    endtask

    task automatic vsync_high();
        cam_vsync = 1'b1;
        repeat (3) tick();
    endtask

    task automatic vsync_low();
        cam_vsync = 1'b0;
        exp_addr  = 0;
        wr_count  = 0;
        fd_count  = 0;
        repeat (3) tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b0; cam_vsync = 1'b0; cam_href = 1'b0; cam_data = 8'h00;

        // Reset values
        do_reset();
        check("rst_w_en", 32'(w_en), 0);
        check("rst_w_data", 32'(w_data), 0);
        check("rst_w_addr", 32'(w_addr), 0);
        check("rst_frame_done", 32'(frame_done), 0);
        check("rst_line_err", 32'(line_err), 0);
        check("rst_overflow", 32'(overflow), 0);

        // Mid-frame start: lines before any vsync are ignored
        send_line(8, 8'h05, 8'h67);
        check("midframe_no_writes", 32'(wr_count), 0);

        // Full frame of 0xABC
        vsync_high();
        vsync_low();
        repeat (H) send_line(8, 8'h0A, 8'hBC);
        vsync_high();
        check("full_writes", 32'(wr_count), 12);
        check("full_frame_done", 32'(fd_count), 1);
        check("full_w_addr_hold", 32'(w_addr), 12);
        check("full_line_err", 32'(line_err), 0);
        check("full_overflow", 32'(overflow), 0);

        // Short line (7 bytes): 3 writes, dangling byte dropped, next line realigned
        vsync_low();
        send_line(7, 8'h0A, 8'hBC);
        check("short_writes", 32'(wr_count), 3);
        check("short_line_err", 32'(line_err), 1);
        send_line(8, 8'h01, 8'h23);
        check("after_short_writes", 32'(wr_count), 7);
        check("after_short_addr", 32'(w_addr), 7);
        send_line(8, 8'h0A, 8'hBC);
        vsync_high();
        check("short_frame_writes", 32'(wr_count), 11);
        check("short_frame_done", 32'(fd_count), 1);

        // One extra line: suppressed writes and overflow
        do_reset();
        vsync_high();
        vsync_low();
        repeat (H + 1) send_line(8, 8'h0A, 8'hBC);
        check("ovf_writes", 32'(wr_count), 12);
        check("ovf_flag", 32'(overflow), 1);
        check("ovf_w_addr", 32'(w_addr), 12);
        check("ovf_line_err", 32'(line_err), 0);
        vsync_high();

        // Pin-to-strobe latency for the first pixel
        do_reset();
        vsync_high();
        vsync_low();
        exp_data = 12'h567;
        cam_href = 1'b1; cam_data = 8'h05;
        tick();
        cam_data = 8'h67;
        tick();
        check("lat_early_w_en", 32'(w_en), 0);
        cam_href = 1'b0; cam_data = 8'h00;
        tick();
        check("lat_w_en", 32'(w_en), 1);
        check("lat_w_data", 32'(w_data), 32'h567);
        check("lat_w_addr", 32'(w_addr), 0);
        repeat (3) tick();
        check("lat_short_line_err", 32'(line_err), 1);

        // Reset in the middle of a line, then recovery
        do_reset();
        vsync_high();
        vsync_low();
        send_line(8, 8'h0A, 8'hBC);
        cam_href = 1'b1;
        cam_data = 8'h0A; tick();
        cam_data = 8'hBC; tick();
        cam_data = 8'h0A; tick();
        check("pre_rst_w_addr", 32'(w_addr), 4);
        rst = 1'b1;
        cam_data = 8'hBC; tick();
        check("midrst_w_en", 32'(w_en), 0);
        check("midrst_w_addr", 32'(w_addr), 0);
        check("midrst_w_data", 32'(w_data), 0);
        check("midrst_frame_done", 32'(frame_done), 0);
        check("midrst_line_err", 32'(line_err), 0);
        rst = 1'b0;
        cam_data = 8'h0A; tick();
        cam_data = 8'hBC; tick();
        cam_href = 1'b0; cam_data = 8'h00;
        repeat (4) tick();
        send_line(8, 8'h0A, 8'hBC);
        check("post_rst_no_writes", 32'(wr_count), 5);
        vsync_high();
        vsync_low();
        repeat (H) send_line(8, 8'h0F, 8'hF0);
        vsync_high();
        check("recover_writes", 32'(wr_count), 12);
        check("recover_frame_done", 32'(fd_count), 1);
        check("recover_w_addr", 32'(w_addr), 12);
        check("recover_line_err", 32'(line_err), 0);

        // Vsync rises while a line is still open
        vsync_low();
        send_line(8, 8'h0A, 8'hBC);
        cam_href = 1'b1;
        cam_data = 8'h0A; tick();
        cam_data = 8'hBC; tick();
        cam_data = 8'h0A; tick();
        cam_vsync = 1'b1;
        cam_data = 8'hBC; tick();
        cam_href = 1'b0; cam_data = 8'h00;
        repeat (3) tick();
        check("trunc_writes", 32'(wr_count), 5);
        check("trunc_frame_done", 32'(fd_count), 1);
        check("trunc_line_err", 32'(line_err), 1);
        check("trunc_w_addr", 32'(w_addr), 5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
